// File: rtl/hld_rd_req_arbiter_if.sv
// Bundles the accelerator-side and memory-side read channels of hld_rd_req_arbiter.
// master: the arbiter; slave: the surrounding FIFOs and memory interface.
interface hld_rd_req_arbiter_if #(
  parameter int unsigned NPORTS = 2
);
  localparam int unsigned REQ_W  = 80;
  localparam int unsigned RESP_W = 528;

  logic [NPORTS-1:0]       acc_req_valid;
  logic [NPORTS-1:0]       acc_req_ready;
  logic [REQ_W*NPORTS-1:0] acc_req_data;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [REQ_W-1:0]        mem_req_data;
  logic                    mem_resp_valid;
  logic                    mem_resp_ready;
  logic [RESP_W-1:0]       mem_resp_data;
  logic [NPORTS-1:0]       acc_resp_valid;
  logic [NPORTS-1:0]       acc_resp_ready;
  logic [RESP_W-1:0]       acc_resp_data;
  logic                    idle;

  modport master (
    input  acc_req_valid, acc_req_data, mem_req_ready, mem_resp_valid, mem_resp_data, acc_resp_ready,
    output acc_req_ready, mem_req_valid, mem_req_data, mem_resp_ready, acc_resp_valid, acc_resp_data, idle
  );

  modport slave (
    output acc_req_valid, acc_req_data, mem_req_ready, mem_resp_valid, mem_resp_data, acc_resp_ready,
    input  acc_req_ready, mem_req_valid, mem_req_data, mem_resp_ready, acc_resp_valid, acc_resp_data, idle
  );
endinterface

// File: rtl/hld_rd_req_arbiter.sv
// Round-robin arbiter sharing one read-request channel among NPORTS ports, with tag-based
// response routing and per-port credit limits. Define HLD_RD_ARB_CHECK_EN for simulation checks.
module hld_rd_req_arbiter #(
  parameter int unsigned NPORTS          = 2,
  parameter int unsigned PORT_W          = 3,
  parameter int unsigned REQ_TAG_LSB     = 64,
  parameter int unsigned RESP_TAG_LSB    = 512,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic clk,
  input  logic rst,
  hld_rd_req_arbiter_if.master bus
);
  localparam int unsigned REQ_W = 80;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = PORT_W + 1;

  logic [PORT_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt [NPORTS];
  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] elig_rot;
  logic [NPORTS-1:0] inc;
  logic [NPORTS-1:0] dec;
  logic              free;
  logic              grant_any;
  logic              cnt_all_zero;
  logic [SUM_W-1:0]  grant_sum;
  logic [PORT_W-1:0] grant_idx;
  logic [PORT_W-1:0] ptr_next;
  logic [REQ_W-1:0]  grant_data;
  logic [PORT_W-1:0] resp_tag;

  // Grant search: eligible set rotated so bit 0 is the port at ptr, lowest set bit wins
  always_comb begin
    free = !bus.mem_req_valid || bus.mem_req_ready;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      elig[i] = free && bus.acc_req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
    elig_rot  = NPORTS'({elig, elig} >> ptr);
    grant_any = 1'b0;
    grant_sum = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (!grant_any && elig_rot[k]) begin
        grant_any = 1'b1;
        grant_sum = SUM_W'(ptr) + SUM_W'(k);
      end
    end
    if (grant_sum >= SUM_W'(NPORTS)) grant_sum = grant_sum - SUM_W'(NPORTS);
    grant_idx = PORT_W'(grant_sum);
    ptr_next  = (grant_idx == PORT_W'(NPORTS - 1)) ? '0 : grant_idx + PORT_W'(1);

    bus.acc_req_ready = '0;
    grant_data        = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (grant_any && grant_idx == PORT_W'(i)) begin
        bus.acc_req_ready[i] = 1'b1;
        grant_data           = bus.acc_req_data[i*REQ_W +: REQ_W];
      end
    end
    grant_data[REQ_TAG_LSB +: PORT_W] = grant_idx;
    inc = bus.acc_req_ready & bus.acc_req_valid;
  end

  // Response steering by tag; out-of-range tags are swallowed with ready held high
  always_comb begin
    resp_tag           = bus.mem_resp_data[RESP_TAG_LSB +: PORT_W];
    bus.acc_resp_valid = '0;
    bus.mem_resp_ready = 1'b1;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (resp_tag == PORT_W'(i)) begin
        bus.acc_resp_valid[i] = bus.mem_resp_valid;
        bus.mem_resp_ready    = bus.acc_resp_ready[i];
      end
    end
    dec = bus.acc_resp_valid & bus.acc_resp_ready;
  end

  assign bus.acc_resp_data = bus.mem_resp_data;

  always_comb begin
    cnt_all_zero = 1'b1;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (cnt[i] != '0) cnt_all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_data  <= '0;
      bus.idle          <= 1'b1;
      ptr               <= '0;
      for (int unsigned i = 0; i < NPORTS; i++) cnt[i] <= '0;
    end else begin
      if (grant_any) begin
        bus.mem_req_valid <= 1'b1;
        bus.mem_req_data  <= grant_data;
        ptr               <= ptr_next;
      end else if (bus.mem_req_ready) begin
        bus.mem_req_valid <= 1'b0;
      end
      // Credits never exceed MAX_OUTSTANDING, and late responses saturate at zero
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!inc[i] && dec[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
      bus.idle <= !bus.mem_req_valid && cnt_all_zero;
    end
  end

`ifdef HLD_RD_ARB_CHECK_EN
  logic             chk_stall;
  logic [REQ_W-1:0] chk_data;
  logic             chk_zero;

  always_comb begin
    chk_zero = 1'b0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (resp_tag == PORT_W'(i) && cnt[i] == '0) chk_zero = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_resp_valid && 32'(resp_tag) >= NPORTS) begin
        $display("%m @%0t: response tag %0d out of range", $time, resp_tag);
        $stop(1);
      end
      if (bus.mem_resp_valid && bus.mem_resp_ready && 32'(resp_tag) < NPORTS && chk_zero) begin
        $display("%m @%0t: response to port %0d with zero outstanding", $time, resp_tag);
        $stop(1);
      end
      if (chk_stall && bus.mem_req_data != chk_data) begin
        $display("%m @%0t: mem_req_data changed while stalled", $time);
        $stop(1);
      end
    end
    chk_stall <= bus.mem_req_valid && !bus.mem_req_ready;
    chk_data  <= bus.mem_req_data;
  end
`endif
endmodule

// File: tb/tb_hld_rd_req_arbiter.sv
// Randomized self-checking bench for hld_rd_req_arbiter against a transaction-level model
// (credit counts, nearest-port-in-rotation grant, tag routing), plus directed scenarios.
module tb_hld_rd_req_arbiter;
  localparam int unsigned N      = 3;
  localparam int unsigned PW     = 3;
  localparam int unsigned MAXO   = 4;
  localparam int unsigned REQ_W  = 80;
  localparam int unsigned RESP_W = 528;
  localparam int unsigned QTAG   = 64;
  localparam int unsigned RTAG   = 512;
  localparam int unsigned QWORDS = (N*REQ_W + 31) / 32;
  localparam int unsigned RWORDS = (RESP_W + 31) / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  hld_rd_req_arbiter_if #(.NPORTS(N)) bus();

  hld_rd_req_arbiter #(
    .NPORTS(N), .PORT_W(PW), .REQ_TAG_LSB(QTAG), .RESP_TAG_LSB(RTAG), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference state: output slot, rotation pointer, outstanding count per port
  bit               m_valid;
  logic [REQ_W-1:0] m_data;
  int               m_ptr;
  int               m_cnt [N];
  bit               m_idle;

  task automatic check_eq(input string tag, input logic [RESP_W-1:0] obs, input logic [RESP_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ptr   = 0;
    m_idle  = 1'b1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [N*REQ_W-1:0] rnd_req();
    logic [QWORDS*32-1:0] t;
    for (int i = 0; i < QWORDS; i++) t[i*32 +: 32] = $urandom;
    return t[N*REQ_W-1:0];
  endfunction

  function automatic logic [RESP_W-1:0] resp_with_tag(input int tag);
    logic [RWORDS*32-1:0] t;
    for (int i = 0; i < RWORDS; i++) t[i*32 +: 32] = $urandom;
    t[RTAG +: PW] = PW'(tag);
    return t[RESP_W-1:0];
  endfunction

  // One clock: drive inputs, check combinational outputs, advance model, check registers
  task automatic step(input logic [N-1:0] rv, input logic [N*REQ_W-1:0] rd, input logic mrr,
                      input logic rsv, input logic [RESP_W-1:0] rsd, input logic [N-1:0] arr,
                      output logic [N-1:0] o_rdy, output logic [N-1:0] o_rv);
    int               granted, bestd, d, tag, deliver;
    bit               all_zero;
    logic [N-1:0]     exp_rdy, exp_rv;
    logic             exp_rr;
    logic [REQ_W-1:0] ld;
    bus.acc_req_valid  = rv;
    bus.acc_req_data   = rd;
    bus.mem_req_ready  = mrr;
    bus.mem_resp_valid = rsv;
    bus.mem_resp_data  = rsd;
    bus.acc_resp_ready = arr;
    #1;
    granted = -1;
    bestd   = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if ((!m_valid || mrr) && rv[i] && m_cnt[i] < MAXO && d < bestd) begin
        bestd   = d;
        granted = i;
      end
    end
    exp_rdy = (granted >= 0) ? N'(1 << granted) : '0;
    tag     = int'(rsd[RTAG +: PW]);
    deliver = -1;
    if (tag < N) begin
      exp_rv = rsv ? N'(1 << tag) : '0;
      exp_rr = arr[tag];
      if (rsv && arr[tag]) deliver = tag;
    end else begin
      exp_rv = '0;
      exp_rr = 1'b1;
    end
    o_rdy = bus.acc_req_ready;
    o_rv  = bus.acc_resp_valid;
    check_eq("acc_req_ready", bus.acc_req_ready, exp_rdy);
    check_eq("acc_resp_valid", bus.acc_resp_valid, exp_rv);
    check_eq("mem_resp_ready", bus.mem_resp_ready, exp_rr);
    check_eq("acc_resp_data", bus.acc_resp_data, rsd);

    all_zero = 1'b1;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all_zero = 1'b0;
    m_idle = !m_valid && all_zero;
    if (granted >= 0) begin
      ld            = rd[granted*REQ_W +: REQ_W];
      ld[QTAG +: PW] = PW'(granted);
      m_valid       = 1'b1;
      m_data        = ld;
      m_ptr         = (granted + 1) % N;
    end else if (mrr) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = m_cnt[i] + ((i == granted) ? 1 : 0) - ((i == deliver) ? 1 : 0);
      if (m_cnt[i] < 0) m_cnt[i] = 0;
    end

    @(posedge clk);
    #1;
    check_eq("mem_req_valid", bus.mem_req_valid, m_valid);
    if (m_valid) check_eq("mem_req_data", bus.mem_req_data, m_data);
    check_eq("idle", bus.idle, m_idle);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    bus.acc_req_valid  = '0;
    bus.mem_resp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check_eq("rst_mem_req_data", bus.mem_req_data, '0);
    check_eq("rst_idle", bus.idle, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : main
    logic [N-1:0]       rdy, rv;
    logic [N*REQ_W-1:0] rd;
    logic [RESP_W-1:0]  rsd;
    int                 acc, tag, sel;
    bit                 did_reset;
    int                 live [$];

    bus.acc_req_valid  = '0;
    bus.acc_req_data   = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.acc_resp_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_mem_req_valid", bus.mem_req_valid, 1'b0);
    check_eq("init_mem_req_data", bus.mem_req_data, '0);
    check_eq("init_idle", bus.idle, 1'b1);
    rst = 1'b0;

    // Round-robin with every port requesting
    for (int k = 0; k < 6; k++) begin
      step('1, rnd_req(), 1'b1, 1'b0, '0, '0, rdy, rv);
      check_eq("rr_tag", bus.mem_req_data[QTAG +: PW], PW'(k % N));
    end
    do_reset();

    // Credit limit on port 0, then one response frees one credit
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      step(N'(1), rnd_req(), 1'b1, 1'b0, '0, '0, rdy, rv);
      acc += int'(rdy[0]);
    end
    check_eq("credit_accepts", acc, 4);
    acc = 0;
    step(N'(1), rnd_req(), 1'b1, 1'b1, resp_with_tag(0), N'(1), rdy, rv);
    acc += int'(rdy[0]);
    for (int k = 0; k < 3; k++) begin
      step(N'(1), rnd_req(), 1'b1, 1'b0, '0, '0, rdy, rv);
      acc += int'(rdy[0]);
    end
    check_eq("credit_after_resp", acc, 1);
    do_reset();

    // Backpressure: loaded request held while mem_req_ready is low
    rd = rnd_req();
    rd[REQ_W-1:0] = 80'h0000_DEAD_BEEF_0000_00AB;
    step(N'(1), rd, 1'b1, 1'b0, '0, '0, rdy, rv);
    for (int k = 0; k < 5; k++) begin
      step(N'(3), rnd_req(), 1'b0, 1'b0, '0, '0, rdy, rv);
      check_eq("bp_ready", rdy, '0);
      check_eq("bp_data", bus.mem_req_data, 80'h0000_DEAD_BEEF_0000_00AB);
    end

    // Response routing by tag, including an out-of-range tag
    step('0, rnd_req(), 1'b1, 1'b1, resp_with_tag(1), '1, rdy, rv);
    check_eq("route_tag1", rv, N'(2));
    step('0, rnd_req(), 1'b1, 1'b1, resp_with_tag(0), '1, rdy, rv);
    check_eq("route_tag0", rv, N'(1));
    step('0, rnd_req(), 1'b1, 1'b1, resp_with_tag(5), '0, rdy, rv);
    check_eq("route_tag5", rv, '0);
    check_eq("route_tag5_ready", bus.mem_resp_ready, 1'b1);
    do_reset();

    // Port-1 accept and response in the same cycle leave its count unchanged
    for (int k = 0; k < 3; k++) step(N'(2), rnd_req(), 1'b1, 1'b0, '0, '0, rdy, rv);
    step(N'(2), rnd_req(), 1'b1, 1'b1, resp_with_tag(1), N'(2), rdy, rv);
    check_eq("simul_accept", rdy, N'(2));
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      step(N'(2), rnd_req(), 1'b1, 1'b0, '0, '0, rdy, rv);
      acc += int'(rdy[1]);
    end
    check_eq("simul_cnt", acc, 1);

    // Randomized traffic with one reset taken while requests are in flight
    did_reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!did_reset && ((cyc > 500 && m_cnt[0] == 2 && m_valid) || cyc == 2000)) begin
        did_reset = 1'b1;
        do_reset();
      end
      sel = $urandom_range(0, 9);
      live.delete();
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) live.push_back(i);
      if (sel < 6 && live.size() > 0) tag = live[$urandom_range(0, live.size() - 1)];
      else if (sel < 8) tag = $urandom_range(N, (1 << PW) - 1);
      else tag = $urandom_range(0, N - 1);
      rsd = resp_with_tag(tag);
      step(N'($urandom_range(0, (1 << N) - 1)), rnd_req(), ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), rsd, N'($urandom_range(0, (1 << N) - 1)), rdy, rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
